// File: rtl/conv_sched_if.sv
// Handshake and configuration bundle between the conv scheduler (slave view)
// and its environment: job control, conv core issue/return and result stream.
interface conv_sched_if;
  logic               start;
  logic [7:0]         cfg_cin;
  logic [15:0]        cfg_npix;
  logic               busy;
  logic               done;
  logic               sat;
  logic               core_in_valid;
  logic               core_in_ready;
  logic [7:0]         cur_cin;
  logic [15:0]        cur_pix;
  logic               core_out_valid;
  logic               core_out_ready;
  logic signed [31:0] core_partial;
  logic               res_valid;
  logic               res_ready;
  logic signed [31:0] res_data;
  logic [15:0]        res_pix;

  modport master (
    output start, cfg_cin, cfg_npix, core_in_ready, core_out_valid, core_partial, res_ready,
    input  busy, done, sat, core_in_valid, cur_cin, cur_pix, core_out_ready,
           res_valid, res_data, res_pix
  );

  modport slave (
    input  start, cfg_cin, cfg_npix, core_in_ready, core_out_valid, core_partial, res_ready,
    output busy, done, sat, core_in_valid, cur_cin, cur_pix, core_out_ready,
           res_valid, res_data, res_pix
  );
endinterface

// File: rtl/conv_sched.sv
// Convolution scheduler: issues one window/weight per input channel, accumulates
// the returned partials with saturation and emits one result per output pixel.
module conv_sched (
  input  logic         clk,
  input  logic         rst_n,
  conv_sched_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, EMIT} state_t;

  state_t             state, state_nxt;
  logic [7:0]         cin_cfg, cin;
  logic [15:0]        npix_cfg, pix;
  logic signed [31:0] acc;
  logic               sat_q, done_q;
  logic signed [32:0] sum_p0;
  logic               cfg_ok, last_cin, last_pix, clamp;

  function automatic logic signed [31:0] sat32(input logic signed [32:0] s);
    logic signed [31:0] r;
    if (s[32] != s[31]) r = s[32] ? 32'sh8000_0000 : 32'sh7FFF_FFFF;
    else                r = s[31:0];
    return r;
  endfunction

  assign cfg_ok   = (bus.cfg_cin != 8'd0) && (bus.cfg_npix != 16'd0);
  assign last_cin = (cin == cin_cfg - 8'd1);
  assign last_pix = (pix == npix_cfg - 16'd1);
  assign sum_p0   = {acc[31], acc} + {bus.core_partial[31], bus.core_partial};
  assign clamp    = sum_p0[32] ^ sum_p0[31];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.start && cfg_ok) state_nxt = ISSUE;
      ISSUE:   if (bus.core_in_ready) state_nxt = WAIT;
      WAIT:    if (bus.core_out_valid) state_nxt = last_cin ? EMIT : ISSUE;
      EMIT:    if (bus.res_ready) state_nxt = last_pix ? IDLE : ISSUE;
      default: state_nxt = IDLE;
    endcase
  end

  // Counters, accumulator and status flags
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cin_cfg  <= '0;
      npix_cfg <= '0;
      cin      <= '0;
      pix      <= '0;
      acc      <= '0;
      sat_q    <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            sat_q <= 1'b0;
            if (cfg_ok) begin
              cin_cfg  <= bus.cfg_cin;
              npix_cfg <= bus.cfg_npix;
              cin      <= '0;
              pix      <= '0;
              acc      <= '0;
            end else begin
              done_q <= 1'b1;
            end
          end
        end
        WAIT: begin
          if (bus.core_out_valid) begin
            acc <= sat32(sum_p0);
            if (clamp)     sat_q <= 1'b1;
            if (!last_cin) cin   <= cin + 8'd1;
          end
        end
        EMIT: begin
          if (bus.res_ready) begin
            if (last_pix) begin
              done_q <= 1'b1;
            end else begin
              pix <= pix + 16'd1;
              cin <= '0;
              acc <= '0;
            end
          end
        end
        default: ;
      endcase
    end
  end

  // All outputs decode flops only; no input reaches an output combinationally
  assign bus.busy           = (state != IDLE);
  assign bus.done           = done_q;
  assign bus.sat            = sat_q;
  assign bus.core_in_valid  = (state == ISSUE);
  assign bus.core_out_ready = (state == WAIT);
  assign bus.res_valid      = (state == EMIT);
  assign bus.cur_cin        = cin;
  assign bus.cur_pix        = pix;
  assign bus.res_data       = acc;
  assign bus.res_pix        = pix;

endmodule

// File: doc/conv_sched.md
CONV_SCHED -- requirements
Module: conv_sched

Interface
REQ-001 The block SHALL have no parameters; all sizes are run-time configuration latched at start.
REQ-002 clk  input  1  single clock; all state changes on its rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 start  input  1  job request; sampled only in IDLE.
REQ-005 cfg_cin  input  8  input channels accumulated per output pixel.
REQ-006 cfg_npix  input  16  output pixels per job.
REQ-007 busy  output  1  high whenever state is not IDLE.
REQ-008 done  output  1  one-cycle pulse at job completion.
REQ-009 sat  output  1  sticky flag: any accumulation in the current job saturated.
REQ-010 core_in_valid  output  1  window/weight issue request to the conv core.
REQ-011 core_in_ready  input  1  conv core accepts the issue.
REQ-012 cur_cin  output  8  channel index of the current issue, used to address the window buffer.
REQ-013 cur_pix  output  16  pixel index of the current issue, used to address the window buffer.
REQ-014 core_out_valid  input  1  conv core partial available.
REQ-015 core_out_ready  output  1  scheduler consumes the partial.
REQ-016 core_partial  input  32  signed partial sum from the conv core.
REQ-017 res_valid  output  1  accumulated pixel result available.
REQ-018 res_ready  input  1  downstream accepts the result.
REQ-019 res_data  output  32  signed accumulated result.
REQ-020 res_pix  output  16  pixel index of res_data.

Function
REQ-021 The FSM SHALL have exactly four states: IDLE, ISSUE, WAIT and EMIT.
REQ-022 In IDLE, start with a nonzero cfg_cin and a nonzero cfg_npix SHALL latch both config values, clear cin/pix counters, the accumulator and sat, and go to ISSUE.
REQ-023 In IDLE, start with cfg_cin==0 or cfg_npix==0 SHALL pulse done on the next cycle, clear sat and remain in IDLE.
REQ-024 start SHALL be ignored outside IDLE; changes on cfg_* inputs after latch SHALL have no effect.
REQ-025 ISSUE: core_in_valid=1, cur_cin/cur_pix stable; on core_in_valid&&core_in_ready -> WAIT.
REQ-026 core_in_valid SHALL be high only in ISSUE, so at most one partial is outstanding.
REQ-027 WAIT: core_out_ready=1, and core_out_ready SHALL be 0 in every other state.
REQ-028 On core_out_valid in WAIT, the block SHALL set acc <= sat32(acc + core_partial), computed as a 33-bit signed sum clamped to [-2^31, 2^31-1].
REQ-029 Any clamp SHALL set sat, and sat SHALL hold until the next accepted start.
REQ-030 From WAIT, a consumed partial with cin==cfg_cin-1 SHALL go to EMIT; otherwise cin SHALL increment and the FSM SHALL go to ISSUE.
REQ-031 EMIT: res_valid=1, res_data=acc, res_pix=pix, all held stable until res_ready.
REQ-032 On res_ready in EMIT with pix==cfg_npix-1, the FSM SHALL go to IDLE, pulse done in that same transition cycle (registered, high for exactly one cycle) and deassert busy.
REQ-033 On res_ready in EMIT otherwise, pix SHALL increment, cin and acc SHALL be cleared, and the FSM SHALL go to ISSUE.
REQ-034 Latency: start accepted at edge T SHALL give core_in_valid high after T; a partial consumed at edge P with the last cin SHALL give res_valid high after P.
REQ-035 Outputs SHALL be registered, with no combinational path from any *_ready/*_valid input to any output.

Reset
REQ-036 With rst_n low, the block SHALL go to IDLE asynchronously, and all counters, acc, sat, done, busy, core_in_valid, core_out_ready, res_valid, res_data and res_pix SHALL be 0.
REQ-037 Reset mid-job SHALL abandon the job without pulsing done; an in-flight core partial arriving after reset SHALL be ignored because core_out_ready=0.

Verification
REQ-038 cin=1, npix=1, partial 4 -> one result with res_data=4 and res_pix=0, then done for one cycle and busy=0.
REQ-039 cin=3, npix=2, partials 4, 40, -14, then -2, 4, 9 -> results 30 at pix 0 and 11 at pix 1, exactly 6 core issues, and cur_cin sequence 0,1,2,0,1,2.
REQ-040 cin=2, partials 0x7FFFFFF0 and 0x00000020 -> res_data=0x7FFFFFFF and sat=1; sat stays 1 until the next start clears it.
REQ-041 res_ready held low for 5 cycles in EMIT -> res_valid, res_data and res_pix stable throughout, and no core_in_valid asserted.
REQ-042 start with cfg_npix=0 -> done pulses once, busy never rises and no core_in_valid is asserted.
REQ-043 rst_n pulsed low in WAIT, then core_out_valid=1 -> partial not consumed, all outputs 0 and no done pulse.
